// File: rtl/status_if.sv
// status_if: flag/interrupt bus between the sequencer/ALU side (master) and the status register (slave).
// Signals (names from the status register's point of view):
//   i_flag_in, i_flag_ctrl, i_flag_mask  ALU flags, flag operation, bit select
//   i_db_in, i_push_b, i_sync            pull byte, B bit of push image, instruction boundary
//   i_nmi_n, i_irq_n, i_int_ack          interrupt pins and interrupt acceptance
//   o_flag, o_push_out                   current P and its push image
//   o_int_req, o_int_nmi                 interrupt request and its kind
interface status_if;
    logic [7:0] i_flag_in;
    logic [2:0] i_flag_ctrl;
    logic [7:0] i_flag_mask;
    logic [7:0] i_db_in;
    logic       i_push_b;
    logic       i_sync;
    logic       i_nmi_n;
    logic       i_irq_n;
    logic       i_int_ack;
    logic [7:0] o_flag;
    logic [7:0] o_push_out;
    logic       o_int_req;
    logic       o_int_nmi;
    modport master (
        output i_flag_in, i_flag_ctrl, i_flag_mask, i_db_in, i_push_b, i_sync, i_nmi_n, i_irq_n, i_int_ack,
        input  o_flag, o_push_out, o_int_req, o_int_nmi
    );
    modport slave (
        input  i_flag_in, i_flag_ctrl, i_flag_mask, i_db_in, i_push_b, i_sync, i_nmi_n, i_irq_n, i_int_ack,
        output o_flag, o_push_out, o_int_req, o_int_nmi
    );
endinterface

// File: rtl/status_reg.sv
// status_reg: 6502 processor status register with NMI/IRQ synchronisation and request logic.
// Ports:
//   i_clk  core clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    status_if.slave carrying the flag operation, interrupt pins and the P/request outputs
module status_reg #(
    parameter logic [7:0] P_RESET = 8'h34
) (
    input  logic     i_clk,
    input  logic     i_rst,
    status_if.slave  bus
);
    logic [7:0] r_p;
    logic       r_nmi_q;
    logic       r_nmi_q2;
    logic       r_irq_q;
    logic       r_nmi_pend;
    logic       r_i_poll;
    logic [7:0] w_p_op;
    logic [7:0] w_p_next;
    logic       w_nmi_edge;
    always_comb begin
        w_p_op = bus.i_flag_ctrl == 3'd1 ? (r_p & ~bus.i_flag_mask) | (bus.i_flag_in & bus.i_flag_mask) :
                 bus.i_flag_ctrl == 3'd2 ? bus.i_db_in :
                 bus.i_flag_ctrl == 3'd3 ? r_p | bus.i_flag_mask :
                 bus.i_flag_ctrl == 3'd4 ? r_p & ~bus.i_flag_mask : r_p;
        // bits 5/4 are hard ones; an accepted interrupt wins over any I write
        w_p_next = w_p_op | 8'h30 | {5'b0, bus.i_int_ack, 2'b0};
    end
    assign w_nmi_edge = r_nmi_q2 & ~r_nmi_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p        <= P_RESET;
            r_nmi_q    <= 1'b1;
            r_nmi_q2   <= 1'b1;
            r_irq_q    <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_i_poll   <= 1'b1;
        end else begin
            r_p        <= w_p_next;
            r_nmi_q    <= bus.i_nmi_n;
            r_nmi_q2   <= r_nmi_q;
            r_irq_q    <= ~bus.i_irq_n;
            // a fresh edge beats a simultaneous ack so no NMI is lost
            r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~bus.i_int_ack);
            // IRQ mask seen by the request logic lags I by one instruction
            r_i_poll   <= bus.i_sync ? r_p[2] : r_i_poll;
        end
    end
    assign bus.o_flag     = r_p;
    assign bus.o_push_out = {r_p[7:6], 1'b1, bus.i_push_b, r_p[3:0]};
    assign bus.o_int_req  = r_nmi_pend | (r_irq_q & ~r_i_poll);
    assign bus.o_int_nmi  = r_nmi_pend;
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: directed and randomized checks of status_reg against a behavioural model.
module tb_status_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    status_if bus();
    status_reg dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit armed = 0;

    byte unsigned m_p;
    bit m_nmi_hist[$];
    bit m_irq_seen;
    bit m_pend;
    bit m_mask_seen;

    function automatic byte unsigned flag_op(byte unsigned p, int op, byte unsigned fin, byte unsigned mask, byte unsigned db);
        case (op)
            1: return (p & ~mask) | (fin & mask);
            2: return db;
            3: return p | mask;
            4: return p & ~mask;
            default: return p;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_p = 8'h34;
            m_nmi_hist = '{1'b1, 1'b1};
            m_irq_seen = 0;
            m_pend = 0;
            m_mask_seen = 1;
            armed = 1;
        end else if (armed) begin
            bit fell;
            fell = m_nmi_hist[0] && !m_nmi_hist[1];
            m_pend = fell || (m_pend && !bus.i_int_ack);
            if (bus.i_sync) m_mask_seen = m_p[2];
            m_p = flag_op(m_p, int'(bus.i_flag_ctrl), bus.i_flag_in, bus.i_flag_mask, bus.i_db_in) | 8'h30;
            if (bus.i_int_ack) m_p = m_p | 8'h04;
            m_irq_seen = !bus.i_irq_n;
            m_nmi_hist.push_back(bus.i_nmi_n);
            void'(m_nmi_hist.pop_front());
        end
    end

    task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("flag", bus.o_flag, m_p);
            cmp("push_out", bus.o_push_out, {m_p[7:6], 1'b1, bus.i_push_b, m_p[3:0]});
            cmp("int_req", {7'b0, bus.o_int_req}, {7'b0, m_pend || (m_irq_seen && !m_mask_seen)});
            cmp("int_nmi", {7'b0, bus.o_int_nmi}, {7'b0, m_pend});
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op(int c, byte unsigned mask, byte unsigned fin = 0, byte unsigned db = 0);
        bus.i_flag_ctrl = 3'(c);
        bus.i_flag_mask = mask;
        bus.i_flag_in = fin;
        bus.i_db_in = db;
        tick();
        bus.i_flag_ctrl = 3'd0;
    endtask

    initial begin
        bus.i_flag_in = 0; bus.i_flag_ctrl = 0; bus.i_flag_mask = 0; bus.i_db_in = 0;
        bus.i_push_b = 0; bus.i_sync = 0; bus.i_nmi_n = 1; bus.i_irq_n = 1; bus.i_int_ack = 0;
        rst = 1;
        tick(2);
        rst = 0;
        cmp("rst_flag", bus.o_flag, 8'h34);
        cmp("rst_req", {7'b0, bus.o_int_req}, 8'h00);
        cmp("rst_push", bus.o_push_out, 8'h24);
        op(1, 8'h83, 8'hC3);
        cmp("alu_masked", bus.o_flag, 8'hB7);
        op(1, 8'hFF, 8'h00);
        cmp("alu_b5b4", bus.o_flag, 8'h30);
        op(2, 8'hFF, 8'h00, 8'h00);
        cmp("pull", bus.o_flag, 8'h30);
        op(3, 8'h09);
        cmp("set", bus.o_flag, 8'h39);
        op(4, 8'h01);
        cmp("clr", bus.o_flag, 8'h38);
        bus.i_push_b = 1; #1;
        cmp("push_b1", bus.o_push_out, 8'h38);
        bus.i_push_b = 0; #1;
        cmp("push_b0", bus.o_push_out, 8'h28);
        op(3, 8'h04);
        bus.i_sync = 1; tick(); bus.i_sync = 0;
        bus.i_irq_n = 0; tick(2);
        cmp("irq_masked", {7'b0, bus.o_int_req}, 8'h00);
        op(4, 8'h04);
        tick();
        cmp("irq_cli_delay", {7'b0, bus.o_int_req}, 8'h00);
        bus.i_sync = 1; tick(); bus.i_sync = 0;
        cmp("irq_after_sync", {7'b0, bus.o_int_req}, 8'h01);
        bus.i_int_ack = 1; tick(); bus.i_int_ack = 0;
        cmp("ack_sets_i", bus.o_flag, 8'h3C);
        bus.i_sync = 1; tick(); bus.i_sync = 0;
        cmp("irq_remasked", {7'b0, bus.o_int_req}, 8'h00);
        bus.i_irq_n = 1; tick(2);
        bus.i_nmi_n = 0; tick();
        cmp("nmi_lat1", {7'b0, bus.o_int_req}, 8'h00);
        tick();
        cmp("nmi_req", {6'b0, bus.o_int_req, bus.o_int_nmi}, 8'h03);
        bus.i_int_ack = 1; tick(); bus.i_int_ack = 0;
        tick(5);
        cmp("nmi_no_retrig", {7'b0, bus.o_int_req}, 8'h00);
        bus.i_nmi_n = 1; tick(2);
        bus.i_nmi_n = 0; tick(2);
        cmp("nmi_second", {7'b0, bus.o_int_nmi}, 8'h01);
        bus.i_nmi_n = 1; tick(2);
        bus.i_nmi_n = 0; tick();
        bus.i_int_ack = 1; tick(); bus.i_int_ack = 0;
        cmp("nmi_ack_collide", {6'b0, bus.o_int_req, bus.o_int_nmi}, 8'h03);
        bus.i_int_ack = 1; tick(); bus.i_int_ack = 0;
        cmp("nmi_cleared", {7'b0, bus.o_int_req}, 8'h00);
        bus.i_int_ack = 1; op(4, 8'h04); bus.i_int_ack = 0;
        cmp("ack_beats_clr", bus.o_flag & 8'h04, 8'h04);
        bus.i_nmi_n = 1; tick(2);
        bus.i_nmi_n = 0; tick();
        rst = 1; bus.i_nmi_n = 1; tick(2); rst = 0;
        cmp("rst_nmi_flight", {7'b0, bus.o_int_req}, 8'h00);
        tick(3);
        cmp("rst_nmi_gone", {7'b0, bus.o_int_req}, 8'h00);
        repeat (3000) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.i_flag_ctrl = 3'($urandom_range(0, 7));
            bus.i_flag_in = 8'($urandom);
            bus.i_flag_mask = 8'($urandom);
            bus.i_db_in = 8'($urandom);
            bus.i_push_b = 1'($urandom);
            bus.i_sync = ($urandom_range(0, 3) == 0);
            bus.i_int_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) bus.i_nmi_n = ~bus.i_nmi_n;
            if ($urandom_range(0, 7) == 0) bus.i_irq_n = ~bus.i_irq_n;
            tick();
        end
        rst = 0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
